// File: rtl/uart_tx_serializer.sv
// UART transmitter: small byte FIFO feeding a start/data/[parity]/stop serializer clocked at bit rate.
// Define UART_TX_PARITY_EN to insert a parity bit after data bit 7 (sense from PARITY_ODD).
module uart_tx_serializer #(
  parameter int FIFO_AW    = 2,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             gatedClk,
  input  logic             reset_n,
  input  logic [7:0]       TxData,
  input  logic             TxValid,
  output logic             TxReady,
  output logic             TxD,
  output logic             TxBusy,
  output logic [FIFO_AW:0] FifoCount
);

  localparam int   DEPTH     = 1 << FIFO_AW;
  localparam logic LAST_STOP = (STOP_BITS == 2);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state, state_nxt;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW-1:0] rd_idx;
  logic [7:0]         shift_reg;
  logic [2:0]         bit_cnt;
  logic               stop_cnt;
  logic               txd_q;
  logic               txd_nxt;
  logic               full, empty, push, pop;

`ifdef UART_TX_PARITY_EN
  logic               parity_bit;
`else
  logic               unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  assign rd_idx    = rd_ptr[FIFO_AW-1:0];
  assign full      = (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]) &&
                     (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]);
  assign empty     = (wr_ptr == rd_ptr);
  assign push      = TxValid & ~full;
  assign TxReady   = ~full;
  assign FifoCount = wr_ptr - rd_ptr;
  assign TxBusy    = (state != IDLE) | ~empty;
  assign TxD       = txd_q;

  always_ff @(posedge gatedClk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= TxData;
  end

  always_ff @(posedge gatedClk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // txd_nxt is the value of the current state's bit; it is registered, so the line lags state by one edge.
  always_comb begin
    state_nxt = state;
    txd_nxt   = 1'b1;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        txd_nxt   = 1'b0;
        state_nxt = DATA;
      end
      DATA: begin
        txd_nxt = shift_reg[0];
`ifdef UART_TX_PARITY_EN
        if (bit_cnt == 3'd7) state_nxt = PARITY;
`else
        if (bit_cnt == 3'd7) state_nxt = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd_nxt   = parity_bit;
        state_nxt = STOP;
      end
`endif
      STOP: begin
        if (stop_cnt == LAST_STOP) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge gatedClk or negedge reset_n) begin
    if (!reset_n) begin
      txd_q      <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      txd_q <= txd_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pop) begin
        shift_reg  <= mem[rd_idx];
`ifdef UART_TX_PARITY_EN
        parity_bit <= (^mem[rd_idx]) ^ PARITY_ODD;
`endif
      end else if (state == DATA) begin
        shift_reg <= shift_reg >> 1;
      end
      if (state == START)     bit_cnt <= '0;
      else if (state == DATA) bit_cnt <= bit_cnt + 3'd1;
      if (state == STOP) stop_cnt <= (stop_cnt == LAST_STOP) ? 1'b0 : 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (8N1/even and 2-stop/odd) against a queue-style frame model.
module tb_uart_tx_serializer;

  logic       clk;
  logic       rst_n;
  logic [7:0] data0, data1;
  logic       valid0, valid1;
  logic       ready0, ready1, txd0, txd1, busy0, busy1;
  logic [2:0] count0, count1;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: per instance a 4-deep byte FIFO and the remaining bits of the frame on the line (LSB next).
  logic [7:0]  mfifo [2][4];
  int          mhead [2];
  int          msize [2];
  logic [15:0] mframe[2];
  int          mlen  [2];
  logic        etxd  [2];

  uart_tx_serializer #(.FIFO_AW(2), .STOP_BITS(1), .PARITY_ODD(1'b0)) dut0 (
    .gatedClk(clk), .reset_n(rst_n), .TxData(data0), .TxValid(valid0),
    .TxReady(ready0), .TxD(txd0), .TxBusy(busy0), .FifoCount(count0));

  uart_tx_serializer #(.FIFO_AW(2), .STOP_BITS(2), .PARITY_ODD(1'b1)) dut1 (
    .gatedClk(clk), .reset_n(rst_n), .TxData(data1), .TxValid(valid1),
    .TxReady(ready1), .TxD(txd1), .TxBusy(busy1), .FifoCount(count1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_frame(input logic [7:0] b, input int sb, input bit odd,
                             output logic [15:0] f, output int n);
    f = '0;
    n = 0;
    f[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin f[n] = b[i]; n++; end
`ifdef UART_TX_PARITY_EN
    f[n] = (^b) ^ odd; n++;
`endif
    for (int s = 0; s < sb; s++) begin f[n] = 1'b1; n++; end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mhead[k] = 0; msize[k] = 0; mframe[k] = '0; mlen[k] = 0; etxd[k] = 1'b1;
    end
  endtask

  task automatic model_edge(input int k, input logic v, input logic [7:0] d);
    int pre;
    logic [7:0] b;
    pre = msize[k];
    if (mlen[k] > 0) begin
      etxd[k]   = mframe[k][0];
      mframe[k] = mframe[k] >> 1;
      mlen[k]--;
    end else begin
      etxd[k] = 1'b1;
    end
    if (mlen[k] == 0 && pre > 0) begin
      b = mfifo[k][mhead[k]];
      mhead[k] = (mhead[k] + 1) % 4;
      msize[k]--;
      build_frame(b, (k == 0) ? 1 : 2, (k == 1), mframe[k], mlen[k]);
    end
    if (v && pre < 4) begin
      mfifo[k][(mhead[k] + msize[k]) % 4] = d;
      msize[k]++;
    end
  endtask

  task automatic check_all();
    chk("txd0",   {7'b0, txd0},   {7'b0, etxd[0]});
    chk("txd1",   {7'b0, txd1},   {7'b0, etxd[1]});
    chk("count0", {5'b0, count0}, 8'(msize[0]));
    chk("count1", {5'b0, count1}, 8'(msize[1]));
    chk("ready0", {7'b0, ready0}, {7'b0, msize[0] < 4});
    chk("ready1", {7'b0, ready1}, {7'b0, msize[1] < 4});
    chk("busy0",  {7'b0, busy0},  {7'b0, (mlen[0] > 0) || (msize[0] > 0)});
    chk("busy1",  {7'b0, busy1},  {7'b0, (mlen[1] > 0) || (msize[1] > 0)});
  endtask

  task automatic step(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    valid0 = v0; data0 = d0; valid1 = v1; data1 = d1;
    @(posedge clk);
    model_edge(0, v0, d0);
    model_edge(1, v1, d1);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0;
    model_clear();
    #1;
    check_all();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] seq0, seq1;
    int t;
    rst_n = 1'b1; valid0 = 1'b0; valid1 = 1'b0; data0 = '0; data1 = '0;
    model_clear();
    #2;
    apply_reset();
    idle(3);

    // single 0x55 frame on the 1-stop instance
    step(1'b1, 8'h55, 1'b0, 8'h00);
    idle(1);
    for (int i = 0; i < 12; i++) begin idle(1); seq0[i] = txd0; end
`ifdef UART_TX_PARITY_EN
    chk("frame_55", seq0[7:0], 8'hAA); chk("frame_55_hi", {4'b0, seq0[11:8]}, 8'h0C);
`else
    chk("frame_55", seq0[7:0], 8'hAA); chk("frame_55_hi", {4'b0, seq0[11:8]}, 8'h0E);
`endif
    chk("busy_after_55", {7'b0, busy0}, 8'h00);

    // 0xA5 on the 2-stop instance
    step(1'b0, 8'h00, 1'b1, 8'hA5);
    idle(1);
    for (int i = 0; i < 12; i++) begin idle(1); seq1[i] = txd1; end
    chk("frame_a5", seq1[7:0], 8'h4A); chk("frame_a5_hi", {4'b0, seq1[11:8]}, 8'h0F);
    chk("busy_after_a5", {7'b0, busy1}, 8'h00);

    // parity sense on 0x07 and 0x03 (both instances start together, parity on edge N+11)
    step(1'b1, 8'h07, 1'b1, 8'h07);
    idle(11);
`ifdef UART_TX_PARITY_EN
    chk("par07_even", {7'b0, txd0}, 8'h01); chk("par07_odd", {7'b0, txd1}, 8'h00);
`endif
    idle(4);
    step(1'b1, 8'h03, 1'b1, 8'h03);
    idle(11);
`ifdef UART_TX_PARITY_EN
    chk("par03_even", {7'b0, txd0}, 8'h00); chk("par03_odd", {7'b0, txd1}, 8'h01);
`endif
    idle(4);

    // fill the FIFO behind a frame in flight, then hold a write of 0xFF
    step(1'b1, 8'hAA, 1'b1, 8'hAA);
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b1, 8'(i));
    chk("full_count", {5'b0, count0}, 8'd4);
    chk("full_ready", {7'b0, ready0}, 8'd0);
    t = 0;
    while (count0 != 3'd3 && t < 40) begin step(1'b1, 8'hFF, 1'b1, 8'hFF); t++; end
    chk("drop_on_full_pop", {5'b0, count0}, 8'd3);
    step(1'b1, 8'hFF, 1'b1, 8'hFF);
    chk("accept_after_pop", {5'b0, count0}, 8'd4);
    idle(80);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 2) == 0, 8'($urandom));

    t = 0;
    while ((busy0 || busy1) && t < 100) begin idle(1); t++; end
    chk("drain", {6'b0, busy0, busy1}, 8'd0);

    // reset during data bit 4 of 0x3C with two bytes queued
    step(1'b1, 8'h3C, 1'b1, 8'h3C);
    step(1'b1, 8'h11, 1'b1, 8'h11);
    step(1'b1, 8'h22, 1'b1, 8'h22);
    idle(5);
    chk("bit4_of_3c", {7'b0, txd0}, 8'd1);
    chk("queued_before_reset", {5'b0, count0}, 8'd2);
    #2;
    apply_reset();
    chk("count_after_reset", {5'b0, count0}, 8'd0);
    idle(15);
    chk("txd_high_after_reset", {6'b0, txd0, txd1}, 8'h03);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit stage directly downstream of the baud-rate clock generator; clocked by its gated bit clock, so one clock edge = one bit time.
- Buffers bytes in a small FIFO and serializes each as start bit, 8 data bits (LSB first), optional parity, stop bit(s) on TxD.
- The writing host issues writes in the same gated-clock domain.

Parameters:
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW (default 4 entries).
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- gatedClk  input  1  bit-rate clock from the baud generator; one rising edge per bit time.
- reset_n  input  1  asynchronous active-low reset.
- TxData  input  8  byte to transmit.
- TxValid  input  1  write request; byte accepted on an edge where TxValid & TxReady.
- TxReady  output  1  FIFO not full.
- TxD  output  1  serial line, idle high; registered.
- TxBusy  output  1  frame in progress or FIFO non-empty.
- FifoCount  output  FIFO_AW+1  number of bytes held in the FIFO.

Behaviour:
- Reset (async): TxD=1, state=IDLE, FIFO pointers=0, FifoCount=0, TxReady=1, TxBusy=0, shift register=0, bit counter=0.
- FIFO: circular buffer with (FIFO_AW+1)-bit read/write pointers.
  - Full when the low bits are equal and the MSBs differ.
  - Empty when the pointers are equal.
  - TxReady = ~full. A write while full is ignored; the pointer does not move.
- Simultaneous write and pop in one cycle: both happen. Count is unchanged. With the FIFO full, TxReady is still 0 that cycle, so the write is dropped.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TxD=1. If the FIFO is non-empty, pop the head into the shift register and go to START. The pop and the transition happen on the same edge.
  - START: TxD=0 for one edge. Then go to DATA with the bit counter at 0.
  - DATA: TxD=shift[0]; shift right each edge; counter increments. After bit 7, go to PARITY if parity is compiled in, otherwise to STOP.
  - PARITY: TxD = ^byte XOR PARITY_ODD for one edge. Then go to STOP.
  - STOP: TxD=1 for STOP_BITS edges.
    - On the last stop edge, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- Latency: a byte written at edge N into an empty, idle block is popped at edge N+1. The start bit appears on TxD from edge N+2.
- TxD is driven from a register; no combinational path from any input to TxD.
- Frame length: 10 bit times (8N1); 11 with parity or 2 stop bits; 12 with both.
- TxBusy = (state != IDLE) | ~empty.
- Reset mid-frame: TxD returns to 1 immediately (async) and the FIFO contents are discarded. The partial frame is not resumed.
- When BitRateSel changes upstream, the frame in progress continues at whatever edge rate arrives; no special handling here.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state present; frame carries a parity bit after bit 7, sense set by PARITY_ODD.
- Undefined: PARITY state and parity logic are absent; DATA goes directly to STOP; PARITY_ODD is ignored.

Test Plan:
- Reset, then a single write of 0x55 with parity off and STOP_BITS=1 -> TxD from edge N+2 is 0,1,0,1,0,1,0,1,0,1; then idle 1. TxBusy drops after the stop bit.
- Four back-to-back writes 0x01,0x02,0x03,0x04, then a fifth 0xFF -> 0xFF is accepted only after the first pop. TxReady is 0 while FifoCount=4. Frames are contiguous with no idle bits between stop and start.
- UART_TX_PARITY_EN defined, PARITY_ODD=0:
  - 0x07 -> parity bit 1.
  - 0x03 -> parity bit 0.
  - Rerun with PARITY_ODD=1 -> parity bits invert.
- STOP_BITS=2, write 0xA5 -> 11-bit frame 0,1,0,1,0,0,1,0,1,1,1.
- Write while full together with a pop on the same edge -> the write is dropped and FifoCount goes 4->3. A write on the next edge is accepted.
- Assert reset_n low during data bit 4 of 0x3C with 2 bytes queued -> TxD=1 immediately and FifoCount=0. After release, TxD stays high and TxBusy=0.
